regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port among NUM_REQ writeback requesters, e.g. ALU result, load result and host/debug port.
- Uses round-robin arbitration with a valid/ready handshake on each requester.
- Also contains a clear sequencer that zeroes registers 1..NUM_REGS-1 through the normal write port.
- Sits between the datapath writeback sources and the register file write port (write_en / write_dest / write_data).

---
 rtl/regfile_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a built-in
// sequencer that zeroes r1..rN-1 through that same port.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dest_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      clear_start_i,
  output logic                      clear_busy_o,
  output logic                      clear_done_o,
  output logic                      rf_write_en_o,
  output logic [ADDR_W-1:0]         rf_write_dest_o,
  output logic [DATA_W-1:0]         rf_write_data_o,
  output logic [1:0]                last_grant_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_e              state_q;
  logic [1:0]          rr_ptr_q;
  logic [ADDR_W-1:0]   clr_idx_q;
  logic                clear_busy_q;
  logic                clear_done_q;
  logic                write_en_q;
  logic [ADDR_W-1:0]   write_dest_q;
  logic [DATA_W-1:0]   write_data_q;
  logic [1:0]          last_grant_q;

  logic [NUM_REQ-1:0]  req_ready_s;
  logic [1:0]          grant_idx_s;
  logic [1:0]          scan_idx_s;
  logic                found_s;
  logic [1:0]          next_ptr_s;
  logic [ADDR_W-1:0]   grant_dest_s;
  logic [DATA_W-1:0]   grant_data_s;
  logic [ADDR_W-1:0]   clr_next_s;

  // (base + offset) mod NUM_REQ, with offset < NUM_REQ
  function automatic logic [1:0] rr_index(input logic [1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

  // Grant the first valid requester at or after rr_ptr; a clear request blocks all grants.
  always_comb begin
    req_ready_s = '0;
    grant_idx_s = 2'd0;
    scan_idx_s  = 2'd0;
    found_s     = 1'b0;
    if ((state_q == ST_IDLE) && !clear_start_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx_s = rr_index(rr_ptr_q, k);
        if (!found_s && req_valid_i[scan_idx_s]) begin
          found_s     = 1'b1;
          grant_idx_s = scan_idx_s;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
    req_ready_s[grant_idx_s] = found_s;
  end

  assign next_ptr_s   = rr_index(grant_idx_s, 1);
  assign grant_dest_s = req_dest_i[int'(grant_idx_s)*ADDR_W +: ADDR_W];
  assign grant_data_s = req_data_i[int'(grant_idx_s)*DATA_W +: DATA_W];
  assign clr_next_s   = clr_idx_q + ADDR_W'(1);

  // Control FSM; the write port, status and grant history are all registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= 2'd0;
      clr_idx_q    <= FIRST_IDX;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      write_en_q   <= 1'b0;
      write_dest_q <= '0;
      write_data_q <= '0;
      last_grant_q <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_start_i) begin
            // The first clear write is presented in the first CLEAR cycle.
            state_q      <= ST_CLEAR;
            clr_idx_q    <= FIRST_IDX;
            write_en_q   <= 1'b1;
            write_dest_q <= FIRST_IDX;
            write_data_q <= '0;
            clear_busy_q <= (FIRST_IDX != LAST_IDX);
            clear_done_q <= (FIRST_IDX == LAST_IDX);
          end else if (found_s) begin
            write_en_q   <= (grant_dest_s != '0);
            write_dest_q <= grant_dest_s;
            write_data_q <= grant_data_s;
            rr_ptr_q     <= next_ptr_s;
            last_grant_q <= grant_idx_s;
            clear_done_q <= 1'b0;
          end else begin
            write_en_q   <= 1'b0;
            clear_done_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q      <= ST_IDLE;
            clr_idx_q    <= FIRST_IDX;
            write_en_q   <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
          end else begin
            // Done and the final write land together; busy drops in that same cycle.
            clr_idx_q    <= clr_next_s;
            write_en_q   <= 1'b1;
            write_dest_q <= clr_next_s;
            write_data_q <= '0;
            clear_busy_q <= (clr_next_s != LAST_IDX);
            clear_done_q <= (clr_next_s == LAST_IDX);
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          clr_idx_q    <= FIRST_IDX;
          write_en_q   <= 1'b0;
          clear_busy_q <= 1'b0;
          clear_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o     = req_ready_s;
  assign clear_busy_o    = clear_busy_q;
  assign clear_done_o    = clear_done_q;
  assign rf_write_en_o   = write_en_q;
  assign rf_write_dest_o = write_dest_q;
  assign rf_write_data_o = write_data_q;
  assign last_grant_o    = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: arbitration, dest-0 drop, clear
// sequencing, reset during clear and ignored clear restarts.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [8:0]  req_dest;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic        rf_write_en;
  logic [2:0]  rf_write_dest;
  logic [15:0] rf_write_data;
  logic [1:0]  last_grant;

  int errors;
  int checks;
  int writes;
  int dones;

  regfile_write_arbiter #(
    .NUM_REQ(3), .DATA_W(16), .ADDR_W(3), .NUM_REGS(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_dest_i      (req_dest),
    .req_data_i      (req_data),
    .req_ready_o     (req_ready),
    .clear_start_i   (clear_start),
    .clear_busy_o    (clear_busy),
    .clear_done_o    (clear_done),
    .rf_write_en_o   (rf_write_en),
    .rf_write_dest_o (rf_write_dest),
    .rf_write_data_o (rf_write_data),
    .last_grant_o    (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] d, input logic [15:0] x);
    req_valid[i]       = v;
    req_dest[i*3 +: 3]  = d;
    req_data[i*16 +: 16] = x;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    req_valid = 3'b000;
    req_dest = 9'd0;
    req_data = 48'd0;
    clear_start = 1'b0;

    // Reset
    #1 rst = 1'b1;
    #2;
    chk("rst_en",    32'(rf_write_en),   32'd0);
    chk("rst_dest",  32'(rf_write_dest), 32'd0);
    chk("rst_data",  32'(rf_write_data), 32'd0);
    chk("rst_busy",  32'(clear_busy),    32'd0);
    chk("rst_done",  32'(clear_done),    32'd0);
    chk("rst_lg",    32'(last_grant),    32'd0);
    chk("rst_ready", 32'(req_ready),     32'd0);
    tick();
    rst = 1'b0;

    // Single request
    set_req(0, 1'b1, 3'd3, 16'h1234);
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 3'd0, 16'h0000);
    chk("single_en",   32'(rf_write_en),   32'd1);
    chk("single_dest", 32'(rf_write_dest), 32'd3);
    chk("single_data", 32'(rf_write_data), 32'h1234);
    chk("single_lg",   32'(last_grant),    32'd0);
    tick();
    chk("single_idle_en", 32'(rf_write_en), 32'd0);

    // Lone req 2 wraps the pointer back to 0
    set_req(2, 1'b1, 3'd4, 16'h5555);
    #1 chk("wrap_ready", 32'(req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 3'd0, 16'h0000);
    chk("wrap_dest", 32'(rf_write_dest), 32'd4);
    chk("wrap_lg",   32'(last_grant),    32'd2);

    // Round robin with all three valid
    set_req(0, 1'b1, 3'd1, 16'h0100);
    set_req(1, 1'b1, 3'd2, 16'h0101);
    set_req(2, 1'b1, 3'd3, 16'h0102);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      chk("rr_en",   32'(rf_write_en),   32'd1);
      chk("rr_dest", 32'(rf_write_dest), 32'((k % 3) + 1));
      chk("rr_data", 32'(rf_write_data), 32'(16'h0100 + 16'(k % 3)));
      chk("rr_lg",   32'(last_grant),    32'(k % 3));
    end
    req_valid = 3'b000;

    // Dest 0 is accepted but never written
    set_req(1, 1'b1, 3'd0, 16'hFFFF);
    #1 chk("d0_ready", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 3'd0, 16'h0000);
    chk("d0_en", 32'(rf_write_en), 32'd0);
    chk("d0_lg", 32'(last_grant),  32'd1);
    set_req(1, 1'b1, 3'd5, 16'h1111);
    set_req(2, 1'b1, 3'd6, 16'h2222);
    #1 chk("d0_fair_ready", 32'(req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 3'd0, 16'h0000);
    chk("d0_fair_dest", 32'(rf_write_dest), 32'd6);
    chk("d0_fair_data", 32'(rf_write_data), 32'h2222);
    chk("d0_fair_lg",   32'(last_grant),    32'd2);
    #1 chk("d0_next_ready", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 3'd0, 16'h0000);
    chk("d0_next_dest", 32'(rf_write_dest), 32'd5);
    chk("d0_next_lg",   32'(last_grant),    32'd1);

    // Clear sequence with a pending requester
    set_req(0, 1'b1, 3'd5, 16'hABCD);
    #1 chk("pre_clr_ready", 32'(req_ready), 32'h1);
    tick();
    chk("pre_clr_en",   32'(rf_write_en),   32'd1);
    chk("pre_clr_dest", 32'(rf_write_dest), 32'd5);
    chk("pre_clr_data", 32'(rf_write_data), 32'hABCD);
    set_req(0, 1'b1, 3'd2, 16'h7777);
    clear_start = 1'b1;
    #1 chk("clr_start_ready", 32'(req_ready), 32'h0);
    tick();
    clear_start = 1'b0;
    #1;
    for (int k = 1; k <= 7; k++) begin
      chk("clr_en",    32'(rf_write_en),   32'd1);
      chk("clr_dest",  32'(rf_write_dest), 32'(k));
      chk("clr_data",  32'(rf_write_data), 32'd0);
      chk("clr_busy",  32'(clear_busy),    32'(k < 7));
      chk("clr_done",  32'(clear_done),    32'(k == 7));
      chk("clr_ready", 32'(req_ready),     32'h0);
      tick();
    end
    chk("post_clr_ready", 32'(req_ready),  32'h1);
    chk("post_clr_done",  32'(clear_done), 32'd0);
    chk("post_clr_en",    32'(rf_write_en), 32'd0);
    tick();
    set_req(0, 1'b0, 3'd0, 16'h0000);
    chk("post_clr_dest", 32'(rf_write_dest), 32'd2);
    chk("post_clr_data", 32'(rf_write_data), 32'h7777);
    chk("post_clr_lg",   32'(last_grant),    32'd0);

    // Reset in the middle of a clear
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    tick();
    tick();
    chk("mid_en",   32'(rf_write_en),   32'd1);
    chk("mid_dest", 32'(rf_write_dest), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en",   32'(rf_write_en),   32'd0);
    chk("mid_rst_dest", 32'(rf_write_dest), 32'd0);
    chk("mid_rst_data", 32'(rf_write_data), 32'd0);
    chk("mid_rst_busy", 32'(clear_busy),    32'd0);
    chk("mid_rst_done", 32'(clear_done),    32'd0);
    chk("mid_rst_lg",   32'(last_grant),    32'd0);
    tick();
    rst = 1'b0;
    chk("mid_hold_en", 32'(rf_write_en), 32'd0);
    tick();
    chk("mid_after_en",   32'(rf_write_en), 32'd0);
    chk("mid_after_busy", 32'(clear_busy),  32'd0);
    set_req(2, 1'b1, 3'd4, 16'h4444);
    #1 chk("mid_req2_ready", 32'(req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 3'd0, 16'h0000);
    chk("mid_req2_en",   32'(rf_write_en),   32'd1);
    chk("mid_req2_dest", 32'(rf_write_dest), 32'd4);
    chk("mid_req2_lg",   32'(last_grant),    32'd2);

    // clear_start repeated during CLEAR is ignored
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    writes = 0;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      if (rf_write_en) writes++;
      if (clear_done) dones++;
      clear_start = (c == 2) || (c == 4);
      tick();
    end
    clear_start = 1'b0;
    chk("restart_writes", 32'(writes), 32'd7);
    chk("restart_dones",  32'(dones),  32'd1);
    chk("restart_busy",   32'(clear_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
